// File: rtl/ball_pkg.sv
// Shared types and constants for the ball trajectory block: FSM states,
// fixed-point widths and the Q0.8 cosine table for the 17 launch angles.
package ball_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLIGHT,
    LANDED
  } state_e;

  localparam int POS_W   = 16;
  localparam int VEL_W   = 12;
  localparam int FRAC    = 4;
  localparam int TRIG_W  = 9;
  localparam int ANG_MAX = 16;

  // COS[k] = round(256*cos(k*5.625deg)); SIN[k] is COS[16-k].
  localparam logic [TRIG_W-1:0] COS_TAB [0:16] = '{
    9'd256, 9'd255, 9'd251, 9'd245, 9'd237, 9'd226, 9'd213, 9'd198,
    9'd181, 9'd162, 9'd142, 9'd121, 9'd98,  9'd74,  9'd50,  9'd25,
    9'd0
  };

endpackage

// File: rtl/ball_trajectory_if.sv
// Launch/frame control, pixel scan coordinates and ball status between the
// selector/VGA side (master) and the trajectory block (slave).
interface ball_trajectory_if;
  logic       launch;
  logic       rearm;
  logic       frame_tick;
  logic [2:0] Vel;
  logic [4:0] Ang;
  logic [9:0] xCount;
  logic [9:0] yCount;
  logic       ball;
  logic       busy;
  logic       landed;
  logic [9:0] ballX;
  logic [9:0] ballY;

  modport master (
    output launch, rearm, frame_tick, Vel, Ang, xCount, yCount,
    input  ball, busy, landed, ballX, ballY
  );

  modport slave (
    input  launch, rearm, frame_tick, Vel, Ang, xCount, yCount,
    output ball, busy, landed, ballX, ballY
  );
endinterface

// File: rtl/ball_trig_lut.sv
// Combinational angle-index to cos/sin lookup in unsigned Q0.8; indices
// above 16 are treated as 16 (straight up).
module ball_trig_lut
  import ball_pkg::*;
(
  input  logic [4:0]        ang_i,
  output logic [TRIG_W-1:0] cos_o,
  output logic [TRIG_W-1:0] sin_o
);

  logic [4:0] ang_c;

  always_comb begin
    ang_c = (ang_i > 5'(ANG_MAX)) ? 5'(ANG_MAX) : ang_i;
    cos_o = COS_TAB[ang_c];
    sin_o = COS_TAB[5'(ANG_MAX) - ang_c];
  end

endmodule

// File: rtl/ball_trajectory.sv
// Ballistic flight of the ball: latches power/angle on launch, integrates
// Q11.4 position once per frame under gravity, and flags ball pixels.
module ball_trajectory
  import ball_pkg::*;
#(
  parameter int START_X    = 31,
  parameter int START_Y    = 425,
  parameter int GROUND_Y   = 440,
  parameter int SCREEN_W   = 640,
  parameter int BALL_SIZE  = 4,
  parameter int SPEED_STEP = 16,
  parameter int GRAVITY    = 2,
  parameter int MAX_FRAMES = 255
) (
  input logic               clk,
  input logic               rst,
  ball_trajectory_if.slave  bus
);

  localparam logic signed [POS_W-1:0] START_XQ = POS_W'(START_X * (1 << FRAC));
  localparam logic signed [POS_W-1:0] START_YQ = POS_W'(START_Y * (1 << FRAC));
  localparam logic signed [POS_W-1:0] GROUND_Q = POS_W'(GROUND_Y * (1 << FRAC));
  localparam logic signed [POS_W-1:0] EDGE_Q   = POS_W'((SCREEN_W - BALL_SIZE) * (1 << FRAC));
  localparam logic signed [VEL_W-1:0] GRAV_Q   = VEL_W'(GRAVITY);
  localparam logic [15:0]             MAX_CNT  = 16'(MAX_FRAMES);

  state_e                  state_q;
  logic signed [POS_W-1:0] x_q, y_q, x_nxt, y_nxt;
  logic signed [VEL_W-1:0] vx_q, vy_q, vy_nxt, vx_load, vy_load;
  logic [15:0]             cnt_q, cnt_nxt;
  logic [2:0]              vel_q;
  logic [4:0]              ang_q;
  logic [TRIG_W-1:0]       cos_w, sin_w;
  logic [20:0]             speed;
  logic                    hit_ground, hit_edge, timeout;
  logic [9:0]              ball_x, ball_y;
  logic [10:0]             bx_end, by_end;
  logic                    ball_d, ball_q, busy_q, landed_q;

  // Truncating scale of speed (Q.4) by a Q0.8 trig factor.
  function automatic logic signed [VEL_W-1:0] scale_trig(input logic [20:0] spd,
                                                         input logic [TRIG_W-1:0] t);
    logic [20:0] prod;
    prod = spd * 21'(t);
    return VEL_W'(prod >> 8);
  endfunction

  function automatic logic signed [POS_W-1:0] clamp_hi(input logic signed [POS_W-1:0] v,
                                                       input logic signed [POS_W-1:0] lim);
    return (v >= lim) ? lim : v;
  endfunction

  ball_trig_lut u_lut (
    .ang_i (ang_q),
    .cos_o (cos_w),
    .sin_o (sin_w)
  );

  always_comb begin
    speed      = (21'(vel_q) + 21'd1) * 21'(SPEED_STEP);
    vx_load    = scale_trig(speed, cos_w);
    vy_load    = scale_trig(speed, sin_w);
    x_nxt      = x_q + {{(POS_W-VEL_W){vx_q[VEL_W-1]}}, vx_q};
    y_nxt      = y_q - {{(POS_W-VEL_W){vy_q[VEL_W-1]}}, vy_q};
    vy_nxt     = vy_q - GRAV_Q;
    cnt_nxt    = cnt_q + 16'd1;
    hit_ground = (y_nxt >= GROUND_Q);
    hit_edge   = (x_nxt >= EDGE_Q);
    timeout    = (cnt_nxt == MAX_CNT);
    ball_x     = x_q[FRAC +: 10];
    ball_y     = y_q[FRAC +: 10];
    bx_end     = {1'b0, ball_x} + 11'(BALL_SIZE);
    by_end     = {1'b0, ball_y} + 11'(BALL_SIZE);
    // A ball above the top edge (negative y) is never drawn.
    ball_d     = (bus.xCount >= ball_x) && ({1'b0, bus.xCount} < bx_end) &&
                 (bus.yCount >= ball_y) && ({1'b0, bus.yCount} < by_end) &&
                 !y_q[POS_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= START_XQ;
      y_q      <= START_YQ;
      vx_q     <= '0;
      vy_q     <= '0;
      cnt_q    <= '0;
      vel_q    <= '0;
      ang_q    <= '0;
      ball_q   <= 1'b0;
      busy_q   <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      ball_q <= ball_d;
      case (state_q)
        IDLE: begin
          if (bus.launch) begin
            vel_q   <= bus.Vel;
            ang_q   <= bus.Ang;
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          vx_q    <= vx_load;
          vy_q    <= vy_load;
          state_q <= FLIGHT;
        end
        FLIGHT: begin
          if (bus.frame_tick) begin
            x_q   <= clamp_hi(x_nxt, EDGE_Q);
            y_q   <= clamp_hi(y_nxt, GROUND_Q);
            vy_q  <= vy_nxt;
            cnt_q <= cnt_nxt;
            if (hit_ground || hit_edge || timeout) begin
              state_q  <= LANDED;
              busy_q   <= 1'b0;
              landed_q <= 1'b1;
            end
          end
        end
        LANDED: begin
          if (bus.rearm) begin
            state_q  <= IDLE;
            landed_q <= 1'b0;
            x_q      <= START_XQ;
            y_q      <= START_YQ;
            vx_q     <= '0;
            vy_q     <= '0;
            cnt_q    <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ball   = ball_q;
  assign bus.busy   = busy_q;
  assign bus.landed = landed_q;
  assign bus.ballX  = ball_x;
  assign bus.ballY  = ball_y;

endmodule

// File: tb/tb_ball_trajectory.sv
// Bench for ball_trajectory: a default-gravity and a zero-gravity instance
// share one stimulus stream and are compared every cycle against a model.
module tb_ball_trajectory;

  logic       clk = 1'b0;
  logic       rst, launch, rearm, frame_tick;
  logic [2:0] vel;
  logic [4:0] ang;
  logic [9:0] xc, yc;

  int n_chk  = 0;
  int n_pass = 0;
  int cos_t[17];

  int m_ph[2], m_x[2], m_y[2], m_vx[2], m_vy[2], m_cnt[2], m_vel[2], m_ang[2];
  bit m_ball[2];

  ball_trajectory_if if0 ();
  ball_trajectory_if if1 ();

  assign if0.launch = launch;      assign if1.launch = launch;
  assign if0.rearm = rearm;        assign if1.rearm = rearm;
  assign if0.frame_tick = frame_tick; assign if1.frame_tick = frame_tick;
  assign if0.Vel = vel;            assign if1.Vel = vel;
  assign if0.Ang = ang;            assign if1.Ang = ang;
  assign if0.xCount = xc;          assign if1.xCount = xc;
  assign if0.yCount = yc;          assign if1.yCount = yc;

  ball_trajectory dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  ball_trajectory #(.GRAVITY(0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic model_reset(input int i);
    m_ph[i] = 0; m_x[i] = 31 * 16; m_y[i] = 425 * 16;
    m_vx[i] = 0; m_vy[i] = 0; m_cnt[i] = 0;
  endtask

  // Advances the model of instance i across one rising edge.
  task automatic model_edge(input int i);
    int g, bx, by, nx, ny;
    bit land;
    g  = (i == 0) ? 2 : 0;
    bx = m_x[i] >>> 4;
    by = m_y[i] >>> 4;
    m_ball[i] = (m_y[i] >= 0) && (int'(xc) >= bx) && (int'(xc) < bx + 4) &&
                (int'(yc) >= by) && (int'(yc) < by + 4);
    if (rst) begin
      m_ball[i] = 1'b0;
      model_reset(i);
    end else if (m_ph[i] == 0) begin
      if (launch) begin
        m_vel[i] = int'(vel);
        m_ang[i] = (ang > 5'd16) ? 16 : int'(ang);
        m_ph[i]  = 1;
      end
    end else if (m_ph[i] == 1) begin
      m_vx[i] = ((m_vel[i] + 1) * 16 * cos_t[m_ang[i]]) / 256;
      m_vy[i] = ((m_vel[i] + 1) * 16 * cos_t[16 - m_ang[i]]) / 256;
      m_ph[i] = 2;
    end else if (m_ph[i] == 2) begin
      if (frame_tick) begin
        nx = m_x[i] + m_vx[i];
        ny = m_y[i] - m_vy[i];
        m_vy[i] = m_vy[i] - g;
        m_cnt[i]++;
        land = (m_cnt[i] == 255);
        if (ny >= 440 * 16) begin ny = 440 * 16; land = 1'b1; end
        if (nx >= 636 * 16) begin nx = 636 * 16; land = 1'b1; end
        m_x[i] = nx;
        m_y[i] = ny;
        if (land) m_ph[i] = 3;
      end
    end else begin
      if (rearm) model_reset(i);
    end
  endtask

  function automatic logic [22:0] exp_vec(input int i);
    return {(m_ph[i] == 1 || m_ph[i] == 2), (m_ph[i] == 3),
            10'(m_x[i] >>> 4), 10'(m_y[i] >>> 4), m_ball[i]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    chk("dut0_outputs", {9'd0, if0.busy, if0.landed, if0.ballX, if0.ballY, if0.ball},
        {9'd0, exp_vec(0)});
    chk("dut1_outputs", {9'd0, if1.busy, if1.landed, if1.ballX, if1.ballY, if1.ball},
        {9'd0, exp_vec(1)});
    launch = 1'b0; rearm = 1'b0; frame_tick = 1'b0;
  endtask

  // Ticks until both instances have landed, then rearms them.
  task automatic fly_out(input int bound);
    int n = 0;
    while (!(if0.landed && if1.landed) && n < bound) begin
      frame_tick = 1'b1;
      cyc();
      n++;
    end
    chk("fly_out_landed", 32'(if0.landed && if1.landed), 32'd1);
    rearm = 1'b1;
    cyc();
  endtask

  initial begin
    int n, bx, by;
    for (int k = 0; k < 17; k++)
      cos_t[k] = $rtoi(256.0 * $cos(k * 5.625 * 3.14159265358979 / 180.0) + 0.5);
    model_reset(0); model_reset(1);
    m_ball[0] = 1'b0; m_ball[1] = 1'b0;
    rst = 1'b1; launch = 1'b0; rearm = 1'b0; frame_tick = 1'b0;
    vel = '0; ang = '0; xc = '0; yc = '0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_busy", 32'(if0.busy), 32'd0);
    chk("rst_landed", 32'(if0.landed), 32'd0);
    chk("rst_ball", 32'(if0.ball), 32'd0);

    // Idle frames leave the ball at rest
    for (int k = 0; k < 10; k++) begin frame_tick = 1'b1; cyc(); end
    chk("idle_ballX", 32'(if0.ballX), 32'd31);
    chk("idle_ballY", 32'(if0.ballY), 32'd425);
    chk("idle_busy", 32'(if0.busy), 32'd0);
    yc = 10'd426;
    for (int x = 28; x < 38; x++) begin
      xc = 10'(x); cyc();
      chk("idle_ball_xsweep", 32'(if0.ball), 32'(x >= 31 && x <= 34));
    end
    xc = 10'd32;
    for (int y = 422; y < 432; y++) begin
      yc = 10'(y); cyc();
      chk("idle_ball_ysweep", 32'(if0.ball), 32'(y >= 425 && y <= 428));
    end
    xc = '0; yc = '0;

    // Flat shot: lands after 16 frames
    vel = 3'd0; ang = 5'd0; launch = 1'b1; cyc(); cyc();
    frame_tick = 1'b1; cyc();
    chk("flat_tick1_x", 32'(if0.ballX), 32'd32);
    chk("flat_tick1_y", 32'(if0.ballY), 32'd425);
    n = 1;
    while (!if0.landed && n < 300) begin frame_tick = 1'b1; cyc(); n++; end
    chk("flat_land_tick", 32'(n), 32'd16);
    chk("flat_land_x", 32'(if0.ballX), 32'd47);
    chk("flat_land_y", 32'(if0.ballY), 32'd440);
    fly_out(400);

    // Vertical shot: rises then lands on frame 27
    vel = 3'd0; ang = 5'd16; launch = 1'b1; cyc(); cyc();
    frame_tick = 1'b1; cyc();
    chk("vert_tick1_y", 32'(if0.ballY), 32'd424);
    chk("vert_tick1_x", 32'(if0.ballX), 32'd31);
    n = 1;
    while (!if0.landed && n < 300) begin frame_tick = 1'b1; cyc(); n++; end
    chk("vert_land_tick", 32'(n), 32'd27);
    chk("vert_land_x", 32'(if0.ballX), 32'd31);
    chk("vert_land_y", 32'(if0.ballY), 32'd440);
    fly_out(400);

    // Zero gravity, full power: right edge on frame 76
    vel = 3'd7; ang = 5'd0; launch = 1'b1; cyc(); cyc();
    n = 0;
    while (!if1.landed && n < 300) begin frame_tick = 1'b1; cyc(); n++; end
    chk("edge_land_tick", 32'(n), 32'd76);
    chk("edge_land_x", 32'(if1.ballX), 32'd636);
    chk("edge_land_y", 32'(if1.ballY), 32'd425);
    fly_out(400);
    chk("edge_rearm_x", 32'(if1.ballX), 32'd31);
    chk("edge_rearm_landed", 32'(if1.landed), 32'd0);

    // Launch with a simultaneous tick, then relaunch attempts in flight
    vel = 3'd0; ang = 5'd0; launch = 1'b1; frame_tick = 1'b1; cyc();
    frame_tick = 1'b1; cyc();
    chk("simul_load_x", 32'(if0.ballX), 32'd31);
    chk("simul_load_busy", 32'(if0.busy), 32'd1);
    frame_tick = 1'b1; cyc();
    chk("simul_first_x", 32'(if0.ballX), 32'd32);
    launch = 1'b1; frame_tick = 1'b1; vel = 3'd7; ang = 5'd16; cyc();
    chk("relaunch_x", 32'(if0.ballX), 32'd33);
    chk("relaunch_busy", 32'(if0.busy), 32'd1);
    launch = 1'b1; cyc();
    frame_tick = 1'b1; cyc();
    chk("relaunch_x2", 32'(if0.ballX), 32'd34);
    fly_out(400);

    // Reset mid-flight, then an immediate relaunch
    vel = 3'd3; ang = 5'd8; launch = 1'b1; cyc(); cyc();
    for (int k = 0; k < 4; k++) begin frame_tick = 1'b1; cyc(); end
    rst = 1'b1; frame_tick = 1'b1; cyc();
    rst = 1'b0;
    chk("midrst_busy", 32'(if0.busy), 32'd0);
    chk("midrst_x", 32'(if0.ballX), 32'd31);
    chk("midrst_y", 32'(if0.ballY), 32'd425);
    launch = 1'b1; cyc();
    chk("postrst_launch_busy", 32'(if0.busy), 32'd1);
    cyc();
    fly_out(400);

    // Randomized traffic against the model
    for (int it = 0; it < 8000; it++) begin
      rst        = ($urandom_range(0, 599) == 0);
      launch     = ($urandom_range(0, 15) == 0);
      rearm      = ($urandom_range(0, 7) == 0);
      frame_tick = $urandom_range(0, 1) == 1;
      vel        = 3'($urandom);
      ang        = 5'($urandom);
      bx = m_x[it % 2] >>> 4;
      by = m_y[it % 2] >>> 4;
      xc = 10'(bx + int'($urandom_range(0, 7)) - 2);
      yc = 10'(by + int'($urandom_range(0, 7)) - 2);
      cyc();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
